mul8_seq: RTL

Sequential 8x8 multiplier built around the existing 8-bit `addsub` block. It instantiates one `addsub` and uses it as its only adder/subtractor. Each cycle it drives `addsub` with the partial-product register and the multiplicand, then consumes `sum`, `cf` and `ovf` to form one shift-add (unsigned) or radix-2 Booth (signed) step. The block is the first sequential consumer of `addsub` in the datapath: one product every 10 cycles, with a start/done handshake.

---
 rtl/mul8_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mul8_seq.sv
// Sequential 8x8 multiplier: unsigned shift-add or signed radix-2 Booth,
// one step per cycle through a shared 8-bit adder/subtractor.

module addsub (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  output logic [7:0] sum,
  output logic       cf,
  output logic       ovf
);
  logic [7:0] b_eff;
  logic [8:0] res;

  always_comb begin
    b_eff = sub ? ~b : b;
    res   = {1'b0, a} + {1'b0, b_eff} + {8'b0, sub};
    sum   = res[7:0];
    cf    = res[8];
    ovf   = (a[7] == b_eff[7]) && (res[7] != a[7]);
  end
endmodule

// state  | meaning
// IDLE   | waiting for start, operands latched on accept
// RUN    | one add/shift step per cycle, 8 steps
// DONE   | product registered, done pulses on the following cycle
module mul8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        zf,
  output logic        sf
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, q_q, m_q;
  logic        q1_q, mode_q;
  logic [2:0]  cnt_q;
  logic [15:0] product_q;
  logic        zf_q, sf_q, done_q;

  logic       as_sub, as_cf, as_ovf;
  logic [7:0] as_sum;
  logic [7:0] s;
  logic       n;

  addsub u_addsub (
    .a   (a_q),
    .b   (m_q),
    .sub (as_sub),
    .sum (as_sum),
    .cf  (as_cf),
    .ovf (as_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == 3'd7) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
  end

  // Subtract only for the Booth 10 pair; kept apart from the sum consumer
  // so the adder feedback is not a combinational loop within one block.
  always_comb begin
    as_sub = mode_q && (q_q[0] == 1'b1) && (q1_q == 1'b0);
  end

  always_comb begin
    s = a_q;
    n = 1'b0;
    if (!mode_q) begin
      if (q_q[0]) begin
        s = as_sum;
        n = as_cf;
      end
    end else begin
      case ({q_q[0], q1_q})
        2'b01, 2'b10: begin
          s = as_sum;
          n = as_sum[7] ^ as_ovf;
        end
        default: n = a_q[7];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      q1_q      <= 1'b0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      zf_q      <= 1'b1;
      sf_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q    <= '0;
            q_q    <= b;
            m_q    <= a;
            q1_q   <= 1'b0;
            mode_q <= sgn;
            cnt_q  <= '0;
          end
        end
        S_RUN: begin
          a_q   <= {n, s[7:1]};
          q_q   <= {s[0], q_q[7:1]};
          q1_q  <= q_q[0];
          cnt_q <= cnt_q + 3'd1;
        end
        S_DONE: begin
          product_q <= {a_q, q_q};
          zf_q      <= ({a_q, q_q} == 16'h0000);
          sf_q      <= a_q[7];
        end
        default: ;
      endcase
    end
  end

  assign done    = done_q;
  assign product = product_q;
  assign zf      = zf_q;
  assign sf      = sf_q;
endmodule
